// File: rtl/fiber_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// fiber_mem_port_arbiter
//
// Shares one single-port SRAM macro (1-cycle registered read) between a write
// requester and a read requester. At most one memory op is issued per cycle,
// chosen round-robin or write-priority with a read anti-starvation limit.
// Read data comes back through a small response FIFO; a read is only granted
// while the FIFO is guaranteed to have room for its data (credit check), so
// downstream backpressure never causes an overflow.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_clk_en              global clock enable, 0 freezes all state
//   i_flush               synchronous clear of all state, no grant that cycle
//   i_tile_en             0 = idle, no grants
//   i_prio_mode           0 = round-robin, 1 = write-priority + starvation limit
//   i_wr_req_*            write request (valid/addr/data), o_wr_req_ready = grant
//   i_rd_req_*            read request (valid/addr), o_rd_req_ready = grant
//   o_rd_data*            read response FIFO head (data/valid), i_rd_data_ready pops
//   o_addr/data/wen/ren_to_mem  SRAM drive (combinational from the grant)
//   i_data_from_mem       SRAM read data, valid the cycle after o_ren_to_mem
//
// Arbiter history register r_last_grant
//   state   | meaning
//   SIDE_RD | last grant was a read (reset/flush value, next contended grant = write)
//   SIDE_WR | last grant was a write (next contended grant in round-robin = read)
// -----------------------------------------------------------------------------
module fiber_mem_port_arbiter #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 64,
    parameter int RESP_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clk_en,
    input  logic              i_flush,
    input  logic              i_tile_en,
    input  logic              i_prio_mode,

    input  logic              i_wr_req_valid,
    output logic              o_wr_req_ready,
    input  logic [ADDR_W-1:0] i_wr_req_addr,
    input  logic [DATA_W-1:0] i_wr_req_data,

    input  logic              i_rd_req_valid,
    output logic              o_rd_req_ready,
    input  logic [ADDR_W-1:0] i_rd_req_addr,

    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_data_valid,
    input  logic              i_rd_data_ready,

    output logic [ADDR_W-1:0] o_addr_to_mem,
    output logic [DATA_W-1:0] o_data_to_mem,
    output logic              o_wen_to_mem,
    output logic              o_ren_to_mem,
    input  logic [DATA_W-1:0] i_data_from_mem
);

    localparam int PTR_W = (RESP_DEPTH > 2) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam int STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        SIDE_RD = 1'b0,
        SIDE_WR = 1'b1
    } side_e;

    side_e             r_last_grant;
    side_e             w_last_grant_nxt;
    logic [STV_W-1:0]  r_starve_cnt;
    logic [STV_W-1:0]  w_starve_cnt_nxt;
    logic              r_prio_q;
    logic              r_inflight;

    logic [DATA_W-1:0] r_fifo_mem [RESP_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_fifo_cnt;

    logic              w_en;
    logic [OCC_W-1:0]  w_occupancy;
    logic              w_rd_credit;
    logic              w_rd_elig;
    logic              w_wr_elig;
    logic              w_grant_wr;
    logic              w_grant_rd;
    logic              w_push;
    logic              w_pop;
    logic              w_prio_changed;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reset is folded into the enable so the combinational outputs are 0
    // the moment reset asserts, not just after the next edge.
    assign w_en = i_clk_en & i_tile_en & ~i_flush & ~i_rst;

    // Credit uses registered state only: the slot for a read is reserved at
    // grant time (inflight) and released only when the FIFO entry is popped.
    assign w_occupancy = {1'b0, r_fifo_cnt} + OCC_W'(r_inflight);
    assign w_rd_credit = w_occupancy < OCC_W'(RESP_DEPTH);
    assign w_rd_elig   = i_rd_req_valid & w_rd_credit;
    assign w_wr_elig   = i_wr_req_valid;

    assign w_prio_changed = (i_prio_mode != r_prio_q);

    always_comb begin
        w_grant_wr = 1'b0;
        w_grant_rd = 1'b0;
        if (w_en) begin
            if (w_wr_elig && w_rd_elig) begin
                if (i_prio_mode) begin
                    if (r_starve_cnt == STV_W'(STARVE_LIMIT)) begin
                        w_grant_rd = 1'b1;
                    end else begin
                        w_grant_wr = 1'b1;
                    end
                end else if (r_last_grant == SIDE_WR) begin
                    w_grant_rd = 1'b1;
                end else begin
                    w_grant_wr = 1'b1;
                end
            end else if (w_wr_elig) begin
                w_grant_wr = 1'b1;
            end else if (w_rd_elig) begin
                w_grant_rd = 1'b1;
            end
        end
    end

    always_comb begin
        w_last_grant_nxt = r_last_grant;
        if (w_grant_wr) begin
            w_last_grant_nxt = SIDE_WR;
        end else if (w_grant_rd) begin
            w_last_grant_nxt = SIDE_RD;
        end
    end

    // Counts cycles where a willing, credit-ready read lost to a write.
    always_comb begin
        w_starve_cnt_nxt = r_starve_cnt;
        if (w_grant_rd || w_prio_changed) begin
            w_starve_cnt_nxt = '0;
        end else if (w_rd_elig && w_grant_wr &&
                     (r_starve_cnt != STV_W'(STARVE_LIMIT))) begin
            w_starve_cnt_nxt = r_starve_cnt + 1'b1;
        end
    end

    assign w_push = r_inflight;
    assign w_pop  = o_rd_data_valid & i_rd_data_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= SIDE_RD;
            r_starve_cnt <= '0;
            r_prio_q     <= 1'b0;
            r_inflight   <= 1'b0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_fifo_cnt   <= '0;
        end else if (i_clk_en) begin
            r_prio_q <= i_prio_mode;
            if (i_flush) begin
                r_last_grant <= SIDE_RD;
                r_starve_cnt <= '0;
                r_inflight   <= 1'b0;
                r_rd_ptr     <= '0;
                r_wr_ptr     <= '0;
                r_fifo_cnt   <= '0;
            end else begin
                r_last_grant <= w_last_grant_nxt;
                r_starve_cnt <= w_starve_cnt_nxt;
                r_inflight   <= w_grant_rd;
                if (w_push) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // Storage needs no reset: its contents are only visible through a valid
    // entry, and the output is forced to 0 when the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (i_clk_en && !i_flush && !i_rst && w_push) begin
            r_fifo_mem[r_wr_ptr] <= i_data_from_mem;
        end
    end

    assign o_rd_data_valid = (r_fifo_cnt != '0);
    assign o_rd_data       = o_rd_data_valid ? r_fifo_mem[r_rd_ptr] : '0;

    assign o_wr_req_ready = w_grant_wr;
    assign o_rd_req_ready = w_grant_rd;

    always_comb begin
        o_wen_to_mem  = 1'b0;
        o_ren_to_mem  = 1'b0;
        o_addr_to_mem = '0;
        o_data_to_mem = '0;
        if (w_grant_wr) begin
            o_wen_to_mem  = 1'b1;
            o_addr_to_mem = i_wr_req_addr;
            o_data_to_mem = i_wr_req_data;
        end else if (w_grant_rd) begin
            o_ren_to_mem  = 1'b1;
            o_addr_to_mem = i_rd_req_addr;
        end
    end

endmodule

// File: tb/tb_fiber_mem_port_arbiter.sv
module tb_fiber_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst, ce, fl, te, pm;
    logic        wv, wr_rdy, rv, rd_rdy, rr;
    logic [8:0]  wa, ra, maddr;
    logic [63:0] wd, rdata, mdata, mdin;
    logic        dv, wen, ren;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fiber_mem_port_arbiter #(
        .ADDR_W(9), .DATA_W(64), .RESP_DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_clk_en(ce), .i_flush(fl),
        .i_tile_en(te), .i_prio_mode(pm),
        .i_wr_req_valid(wv), .o_wr_req_ready(wr_rdy),
        .i_wr_req_addr(wa), .i_wr_req_data(wd),
        .i_rd_req_valid(rv), .o_rd_req_ready(rd_rdy), .i_rd_req_addr(ra),
        .o_rd_data(rdata), .o_rd_data_valid(dv), .i_rd_data_ready(rr),
        .o_addr_to_mem(maddr), .o_data_to_mem(mdata),
        .o_wen_to_mem(wen), .o_ren_to_mem(ren), .i_data_from_mem(mdin)
    );

    // Single-port SRAM with registered read, frozen by clk_en.
    logic [63:0] sram [512];
    initial mdin = 64'h0;
    always @(posedge clk) begin
        if (ce) begin
            if (wen) sram[maddr] <= mdata;
            if (ren) mdin <= sram[maddr];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, " wr_ready"}, wr_rdy, 1'b0);
        chk1({tag, " rd_ready"}, rd_rdy, 1'b0);
        chk1({tag, " wen"}, wen, 1'b0);
        chk1({tag, " ren"}, ren, 1'b0);
        chk({tag, " addr"}, 64'(maddr), 64'h0);
        chk({tag, " data_to_mem"}, mdata, 64'h0);
        chk1({tag, " rd_data_valid"}, dv, 1'b0);
        chk({tag, " rd_data"}, rdata, 64'h0);
    endtask

    typedef struct {
        logic        ce, te, wv;
        logic [8:0]  wa;
        logic [63:0] wd;
        logic        rv;
        logic [8:0]  ra;
        logic        rr;
        logic        e_wr, e_rd;
        logic [8:0]  e_addr;
        logic [63:0] e_dout;
        logic        e_dv;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic c, input logic t, input logic w, input int a,
                                input logic [63:0] d, input logic r, input int b, input logic q,
                                input logic ewr, input logic erd, input int eaddr,
                                input logic [63:0] edout, input logic edv, input logic [63:0] erdata);
        vec_t v;
        v.ce = c; v.te = t; v.wv = w; v.wa = 9'(a); v.wd = d;
        v.rv = r; v.ra = 9'(b); v.rr = q;
        v.e_wr = ewr; v.e_rd = erd; v.e_addr = 9'(eaddr); v.e_dout = edout;
        v.e_dv = edv; v.e_rdata = erdata;
        return v;
    endfunction

    task automatic idle_inputs();
        ce = 1'b1; te = 1'b1; fl = 1'b0;
        wv = 1'b0; wa = '0; wd = '0; rv = 1'b0; ra = '0;
    endtask

    initial begin
        int k, got, ngr;
        logic [8:0] raddr [5];

        // --- stimulus table: writes, enables, RAW, round-robin with credit stall
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1,1, 1,i,64'h100 + 64'(i), 0,0,1, 1,0,i,64'h100 + 64'(i), 0,64'h0));
        tbl.push_back(mk(1,0, 1,9,64'h55,   0,0,1, 0,0,0,64'h0,    0,64'h0));
        tbl.push_back(mk(0,1, 1,9,64'h55,   0,0,1, 0,0,0,64'h0,    0,64'h0));
        tbl.push_back(mk(1,1, 1,3,64'hDEAD, 0,0,1, 1,0,3,64'hDEAD, 0,64'h0));
        tbl.push_back(mk(1,1, 0,0,64'h0,    1,3,1, 0,1,3,64'h0,    0,64'h0));
        tbl.push_back(mk(1,1, 0,0,64'h0,    0,0,1, 0,0,0,64'h0,    0,64'h0));
        tbl.push_back(mk(1,1, 0,0,64'h0,    0,0,1, 0,0,0,64'h0,    1,64'hDEAD));
        tbl.push_back(mk(1,1, 1,3,64'h103,  0,0,1, 1,0,3,64'h103,  0,64'h0));
        tbl.push_back(mk(1,1, 1,10,64'hAA,  1,5,1, 0,1,5,64'h0,    0,64'h0));
        tbl.push_back(mk(1,1, 1,10,64'hAA,  1,5,1, 1,0,10,64'hAA,  0,64'h0));
        tbl.push_back(mk(1,1, 1,10,64'hAA,  1,6,0, 0,1,6,64'h0,    1,64'h105));
        tbl.push_back(mk(1,1, 1,10,64'hAA,  1,6,0, 1,0,10,64'hAA,  1,64'h105));
        tbl.push_back(mk(1,1, 0,0,64'h0,    1,6,1, 0,0,0,64'h0,    1,64'h105));
        tbl.push_back(mk(1,1, 0,0,64'h0,    0,0,1, 0,0,0,64'h0,    1,64'h106));
        tbl.push_back(mk(1,1, 0,0,64'h0,    0,0,1, 0,0,0,64'h0,    0,64'h0));

        // --- reset state, with requests pending
        rst = 1'b1; idle_inputs(); pm = 1'b0; rr = 1'b1;
        wv = 1'b1; wa = 9'd5; wd = 64'h77; rv = 1'b1; ra = 9'd6;
        @(negedge clk); #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0; idle_inputs();

        // --- table
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            ce = tbl[i].ce; te = tbl[i].te; wv = tbl[i].wv; wa = tbl[i].wa; wd = tbl[i].wd;
            rv = tbl[i].rv; ra = tbl[i].ra; rr = tbl[i].rr;
            #1;
            chk1($sformatf("v%0d wr_ready", i), wr_rdy, tbl[i].e_wr);
            chk1($sformatf("v%0d rd_ready", i), rd_rdy, tbl[i].e_rd);
            chk1($sformatf("v%0d wen", i), wen, tbl[i].e_wr);
            chk1($sformatf("v%0d ren", i), ren, tbl[i].e_rd);
            chk($sformatf("v%0d addr", i), 64'(maddr), 64'(tbl[i].e_addr));
            chk($sformatf("v%0d data_to_mem", i), mdata, tbl[i].e_dout);
            chk1($sformatf("v%0d rd_data_valid", i), dv, tbl[i].e_dv);
            chk($sformatf("v%0d rd_data", i), rdata, tbl[i].e_rdata);
        end

        // --- round-robin from a flushed arbiter: W,R,W,R...
        @(negedge clk);
        idle_inputs(); rr = 1'b1; fl = 1'b1; wv = 1'b1; rv = 1'b1; wa = 9'd20;
        #1;
        chk1("rr flush wr_ready", wr_rdy, 1'b0);
        chk1("rr flush rd_ready", rd_rdy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            fl = 1'b0; wa = 9'(20 + i); wd = 64'h200 + 64'(i); ra = 9'(i % 8);
            #1;
            chk1($sformatf("rr%0d wr_ready", i), wr_rdy, (i % 2) == 0);
            chk1($sformatf("rr%0d rd_ready", i), rd_rdy, (i % 2) == 1);
            if (i >= 2) chk1($sformatf("rr%0d rd_data_valid", i), dv, (i % 2) == 1);
            if (i >= 3 && (i % 2) == 1)
                chk($sformatf("rr%0d rd_data", i), rdata, 64'h100 + 64'((i - 2) % 8));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_inputs(); pm = 1'b1;
        end

        // --- write priority: W,W,W,W,R repeating
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            wv = 1'b1; rv = 1'b1; wa = 9'(40 + i); wd = 64'h300 + 64'(i); ra = 9'd0;
            #1;
            chk1($sformatf("wp%0d wr_ready", i), wr_rdy, (i % 5) != 4);
            chk1($sformatf("wp%0d rd_ready", i), rd_rdy, (i % 5) == 4);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_inputs(); pm = 1'b0;
        end
        @(negedge clk);
        fl = 1'b1;

        // --- backpressure: only two reads fit, then in-order drain
        for (int i = 0; i < 5; i++) raddr[i] = 9'(i);
        k = 0; ngr = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            fl = 1'b0; rr = 1'b0; rv = (k < 5); ra = (k < 5) ? raddr[k] : 9'd0;
            #1;
            chk1($sformatf("bp%0d rd_ready", c), rd_rdy, c < 2);
            if (rd_rdy) begin k++; ngr++; end
        end
        chk("bp grants", 64'(ngr), 64'd2);
        chk1("bp held valid", dv, 1'b1);
        chk("bp held data", rdata, 64'h100);
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            rr = 1'b1; rv = (k < 5); ra = (k < 5) ? raddr[k] : 9'd0;
            #1;
            if (dv) begin
                chk($sformatf("bp resp%0d", got), rdata, 64'h100 + 64'(raddr[got]));
                got++;
            end
            if (rd_rdy) k++;
        end
        chk("bp responses", 64'(got), 64'd5);

        // --- clk_en freeze holds the pending inflight capture
        @(negedge clk);
        idle_inputs(); rv = 1'b1; ra = 9'd6;
        #1 chk1("ce read grant", rd_rdy, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rv = 1'b0; wv = 1'b1; wa = 9'd50; ce = 1'b0;
            #1;
            chk1($sformatf("ce%0d wr_ready", i), wr_rdy, 1'b0);
            chk1($sformatf("ce%0d rd_data_valid", i), dv, 1'b0);
        end
        @(negedge clk);
        idle_inputs();
        #1 chk1("ce resume valid", dv, 1'b0);
        @(negedge clk);
        #1;
        chk1("ce data valid", dv, 1'b1);
        chk("ce data", rdata, 64'h106);

        // --- flush with one read in flight and one entry queued
        @(negedge clk);
        idle_inputs(); rr = 1'b0; rv = 1'b1; ra = 9'd1;
        #1 chk1("fl read1 grant", rd_rdy, 1'b1);
        @(negedge clk);
        ra = 9'd2;
        #1 chk1("fl read2 grant", rd_rdy, 1'b1);
        @(negedge clk);
        rv = 1'b0; wv = 1'b1; fl = 1'b1;
        #1;
        chk1("fl pre valid", dv, 1'b1);
        chk("fl pre data", rdata, 64'h101);
        chk1("fl no grant", wr_rdy, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            chk1($sformatf("fl post%0d valid", i), dv, 1'b0);
            chk($sformatf("fl post%0d data", i), rdata, 64'h0);
        end
        @(negedge clk);
        rr = 1'b1; rv = 1'b1; ra = 9'd7;
        #1 chk1("fl credit back", rd_rdy, 1'b1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #1;
        chk1("fl new valid", dv, 1'b1);
        chk("fl new data", rdata, 64'h107);

        // --- async reset mid-operation
        @(negedge clk);
        idle_inputs(); rr = 1'b0; rv = 1'b1; ra = 9'd1;
        @(negedge clk);
        ra = 9'd2;
        @(negedge clk);
        rv = 1'b0; wv = 1'b1; wa = 9'd60; wd = 64'hBEEF;
        #1;
        chk1("rst pre wr_ready", wr_rdy, 1'b1);
        chk1("rst pre valid", dv, 1'b1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async rst");
        @(negedge clk);
        rst = 1'b0; idle_inputs();
        #1 chk1("rst post valid", dv, 1'b0);
        @(negedge clk);
        wv = 1'b1; rv = 1'b1; wa = 9'd61; ra = 9'd0; rr = 1'b1;
        #1;
        chk1("rst first wr", wr_rdy, 1'b1);
        chk1("rst first rd", rd_rdy, 1'b0);
        @(negedge clk);
        #1 chk1("rst second rd", rd_rdy, 1'b1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
